// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame length and baud divider
// arithmetic, used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // start + 8 data + stop
  localparam int FRAME_BITS = 10;
  localparam int CNT_W      = 16;

  function automatic int calc_baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int calc_half(input int clk_freq, input int baud_rate);
    return (clk_freq / baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver output bundle: received byte, its strobe, busy flag and framing error.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;

  modport master (output rx_data, rx_valid, rx_busy, frame_err);
  modport slave  (input  rx_data, rx_valid, rx_busy, frame_err);
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop resynchronizer for the asynchronous serial line. Resets to 1 so
// the line reads as idle while in reset.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // two-stage capture of the raw line into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first.
// Optional build macro UART_RX_MAJORITY_EN: every start/data/stop sample is a
// 2-of-3 vote over three consecutive synchronized samples; the FSM then runs
// one cycle later than in the default build.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a falling edge on an armed (seen-high) line
// ST_START | timing to mid start bit; high there means false start
// ST_DATA  | sampling 8 data bits at one-bit intervals into shreg
// ST_STOP  | sampling stop bit; 1 publishes the byte, 0 flags framing
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rx,
  uart_rx_if.master rx_if
);

  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD_RATE);
  localparam int HALF     = calc_half(CLK_FREQ, BAUD_RATE);
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [2:0]       LAST_BIT = 3'(FRAME_BITS - 3);

  logic rx_s;
  logic rx_line;
  logic rx_smp;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic rx_d1;
  logic rx_d2;

  // sample history for the vote; the FSM watches rx_d1 so the vote is
  // centred on the sample the FSM considers "current"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_d1 <= 1'b1;
      rx_d2 <= 1'b1;
    end else begin
      rx_d1 <= rx_s;
      rx_d2 <= rx_d1;
    end
  end

  assign rx_line = rx_d1;
  assign rx_smp  = (rx_s & rx_d1) | (rx_s & rx_d2) | (rx_d1 & rx_d2);
`else
  assign rx_line = rx_s;
  assign rx_smp  = rx_s;
`endif

  uart_state_t      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic [7:0]       rx_data_q, rx_data_n;
  logic             rx_valid_q, rx_valid_n;
  logic             frame_err_q, frame_err_n;
  logic             armed, armed_n;
  // The synchronizer reset value is not a real observation of the line, so
  // arming waits until the pipeline holds genuine samples.
  logic [2:0]       prime;

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      armed       <= 1'b0;
      prime       <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_idx_n;
      shreg       <= shreg_n;
      rx_data_q   <= rx_data_n;
      rx_valid_q  <= rx_valid_n;
      frame_err_q <= frame_err_n;
      armed       <= armed_n;
      prime       <= {prime[1:0], 1'b1};
    end
  end

  // next-state, bit timing and output pulse decisions
  always_comb begin
    state_n     = state;
    cnt_n       = cnt + 16'd1;
    bit_idx_n   = bit_idx;
    shreg_n     = shreg;
    rx_data_n   = rx_data_q;
    rx_valid_n  = 1'b0;
    frame_err_n = 1'b0;
    armed_n     = armed;
    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (rx_line && prime[2]) armed_n = 1'b1;
        if (!rx_line && armed) state_n = ST_START;
      end
      ST_START: begin
        if (cnt == CNT_HALF) begin
          cnt_n = '0;
          if (rx_smp) begin
            state_n = ST_IDLE;
          end else begin
            state_n   = ST_DATA;
            bit_idx_n = '0;
          end
        end
      end
      ST_DATA: begin
        if (cnt == CNT_BIT) begin
          cnt_n     = '0;
          shreg_n   = {rx_smp, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == LAST_BIT) state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt == CNT_BIT) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
          if (rx_smp) begin
            rx_data_n  = shreg;
            rx_valid_n = 1'b1;
          end else begin
            // a low stop bit may be a break; require the line to go high
            // again before the next start bit is believed
            frame_err_n = 1'b1;
            armed_n     = 1'b0;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign rx_if.rx_data   = rx_data_q;
  assign rx_if.rx_valid  = rx_valid_q;
  assign rx_if.frame_err = frame_err_q;
  assign rx_if.rx_busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at the default 100 MHz / 115200.
module tb_uart_rx;

  localparam int BAUD_DIV = 868;
  localparam int HALF     = 434;
  localparam int LAT_EXP  = 2 + 1 + HALF + 9 * BAUD_DIV;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;

  int cyc       = 0;
  int n_cmp     = 0;
  int n_bad     = 0;
  int n_valid   = 0;
  int n_ferr    = 0;
  int n_both    = 0;
  int busy_cnt  = 0;
  int valid_cyc = 0;
  int t_start   = 0;
  logic [7:0] got_q[$];

  uart_rx_if u_if ();

  uart_rx #(.CLK_FREQ(100000000), .BAUD_RATE(115200)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .rx_if (u_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (u_if.rx_valid) begin
        n_valid++;
        valid_cyc = cyc;
        got_q.push_back(u_if.rx_data);
      end
      if (u_if.frame_err) n_ferr++;
      if (u_if.rx_valid && u_if.frame_err) n_both++;
      if (u_if.rx_busy) busy_cnt++;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Drives up to ncyc cycles of a frame; glitch_at inverts one cycle (-1 = none).
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int glitch_at, input int ncyc);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) t_start = cyc;
      rx = f[i / BAUD_DIV] ^ (i == glitch_at);
    end
  endtask

  task automatic idle_cycles(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rx = v;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (u_if.rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_rx_data: got %h want 00", u_if.rx_data); end
    n_cmp++;
    if (u_if.rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rx_valid: got %b want 0", u_if.rx_valid); end
    n_cmp++;
    if (u_if.rx_busy !== 1'b0) begin n_bad++; $display("FAIL reset_rx_busy: got %b want 0", u_if.rx_busy); end
    n_cmp++;
    if (u_if.frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", u_if.frame_err); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(1'b1, 20);
  endtask

  task automatic test_single;
    int bv, bf, lat;
    bv = n_valid;
    bf = n_ferr;
    send_frame(8'h55, 1'b1, -1, 10 * BAUD_DIV);
    idle_cycles(1'b1, 20);
    @(negedge clk);
    n_cmp++;
    if (n_valid - bv != 1) begin n_bad++; $display("FAIL single_valid_count: got %0d want 1", n_valid - bv); end
    n_cmp++;
    if (got_q[$] !== 8'h55) begin n_bad++; $display("FAIL single_pulse_data: got %h want 55", got_q[$]); end
    n_cmp++;
    if (u_if.rx_data !== 8'h55) begin n_bad++; $display("FAIL single_rx_data: got %h want 55", u_if.rx_data); end
    n_cmp++;
    if (n_ferr - bf != 0) begin n_bad++; $display("FAIL single_frame_err: got %0d want 0", n_ferr - bf); end
    n_cmp++;
    if (u_if.rx_busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_after: got %b want 0", u_if.rx_busy); end
    lat = valid_cyc - t_start;
    n_cmp++;
    if (lat < LAT_EXP - 1 || lat > LAT_EXP + 1) begin
      n_bad++;
      $display("FAIL single_latency: got %0d want %0d +-1", lat, LAT_EXP);
    end
  endtask

  task automatic test_back_to_back;
    int bv, bf, base;
    bv   = n_valid;
    bf   = n_ferr;
    base = got_q.size();
    send_frame(8'hA5, 1'b1, -1, 10 * BAUD_DIV);
    send_frame(8'h3C, 1'b1, -1, 10 * BAUD_DIV);
    idle_cycles(1'b1, 20);
    n_cmp++;
    if (n_valid - bv != 2) begin n_bad++; $display("FAIL b2b_valid_count: got %0d want 2", n_valid - bv); end
    n_cmp++;
    if (got_q[base] !== 8'hA5) begin n_bad++; $display("FAIL b2b_first: got %h want a5", got_q[base]); end
    n_cmp++;
    if (got_q[base+1] !== 8'h3C) begin n_bad++; $display("FAIL b2b_second: got %h want 3c", got_q[base+1]); end
    n_cmp++;
    if (n_ferr - bf != 0) begin n_bad++; $display("FAIL b2b_frame_err: got %0d want 0", n_ferr - bf); end
    n_cmp++;
    if (n_both != 0) begin n_bad++; $display("FAIL pulse_overlap: got %0d want 0", n_both); end
  endtask

  task automatic test_glitch;
    int bv, bf, bb, busy;
    bv = n_valid;
    bf = n_ferr;
    bb = busy_cnt;
    idle_cycles(1'b0, 100);
    idle_cycles(1'b1, 2 * BAUD_DIV);
    busy = busy_cnt - bb;
    n_cmp++;
    if (n_valid - bv != 0) begin n_bad++; $display("FAIL glitch_valid: got %0d want 0", n_valid - bv); end
    n_cmp++;
    if (n_ferr - bf != 0) begin n_bad++; $display("FAIL glitch_frame_err: got %0d want 0", n_ferr - bf); end
    n_cmp++;
    if (busy < 1 || busy >= 440) begin n_bad++; $display("FAIL glitch_busy_cycles: got %0d want 1..439", busy); end
  endtask

  task automatic test_frame_err;
    int bv, bf;
    bv = n_valid;
    bf = n_ferr;
    send_frame(8'hFF, 1'b0, -1, 10 * BAUD_DIV);
    idle_cycles(1'b0, 20 * BAUD_DIV);
    @(negedge clk);
    n_cmp++;
    if (n_ferr - bf != 1) begin n_bad++; $display("FAIL ferr_count: got %0d want 1", n_ferr - bf); end
    n_cmp++;
    if (n_valid - bv != 0) begin n_bad++; $display("FAIL ferr_valid: got %0d want 0", n_valid - bv); end
    n_cmp++;
    if (u_if.rx_data !== 8'h3C) begin n_bad++; $display("FAIL ferr_rx_data_held: got %h want 3c", u_if.rx_data); end
    idle_cycles(1'b1, 100);
    n_cmp++;
    if (n_ferr - bf != 1) begin n_bad++; $display("FAIL ferr_count_after_high: got %0d want 1", n_ferr - bf); end
    n_cmp++;
    if (n_valid - bv != 0) begin n_bad++; $display("FAIL ferr_valid_after_high: got %0d want 0", n_valid - bv); end
  endtask

  task automatic test_reset_mid_frame;
    int bv, bf;
    // start bit plus bits 0..3 and half of bit 4 (which is 0 for 0x81)
    send_frame(8'h81, 1'b1, -1, 5 * BAUD_DIV + HALF);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (u_if.rx_data !== 8'h00) begin n_bad++; $display("FAIL midrst_rx_data: got %h want 00", u_if.rx_data); end
    n_cmp++;
    if (u_if.rx_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_rx_valid: got %b want 0", u_if.rx_valid); end
    n_cmp++;
    if (u_if.rx_busy !== 1'b0) begin n_bad++; $display("FAIL midrst_rx_busy: got %b want 0", u_if.rx_busy); end
    n_cmp++;
    if (u_if.frame_err !== 1'b0) begin n_bad++; $display("FAIL midrst_frame_err: got %b want 0", u_if.frame_err); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    bv = n_valid;
    bf = n_ferr;
    // line still low after release: must not be taken as a start bit
    idle_cycles(1'b0, 200);
    idle_cycles(1'b1, 20);
    send_frame(8'h7E, 1'b1, -1, 10 * BAUD_DIV);
    idle_cycles(1'b1, 20);
    n_cmp++;
    if (n_valid - bv != 1) begin n_bad++; $display("FAIL midrst_valid_count: got %0d want 1", n_valid - bv); end
    n_cmp++;
    if (u_if.rx_data !== 8'h7E) begin n_bad++; $display("FAIL midrst_rx_data_after: got %h want 7e", u_if.rx_data); end
    n_cmp++;
    if (n_ferr - bf != 0) begin n_bad++; $display("FAIL midrst_frame_err_after: got %0d want 0", n_ferr - bf); end
  endtask

  task automatic test_sample_glitch;
    int bv;
    logic [7:0] exp_data;
`ifdef UART_RX_MAJORITY_EN
    exp_data = 8'h00;
`else
    exp_data = 8'h08;
`endif
    bv = n_valid;
    // bit 3 is sampled from the value driven in cycle HALF + 4*BAUD_DIV
    send_frame(8'h00, 1'b1, HALF + 4 * BAUD_DIV, 10 * BAUD_DIV);
    idle_cycles(1'b1, 20);
    n_cmp++;
    if (n_valid - bv != 1) begin n_bad++; $display("FAIL vote_valid_count: got %0d want 1", n_valid - bv); end
    n_cmp++;
    if (u_if.rx_data !== exp_data) begin n_bad++; $display("FAIL vote_rx_data: got %h want %h", u_if.rx_data, exp_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid_frame();
    test_sample_glitch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, SHALL give the clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, SHALL give the line bit rate in bits/s.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 rx  input  1  SHALL be the asynchronous serial line, idle high.
REQ-006 rx_data  output  8  SHALL hold the last correctly framed byte.
REQ-007 rx_valid  output  1  SHALL pulse high for one cycle when rx_data is updated.
REQ-008 rx_busy  output  1  SHALL be high while a frame is being received.
REQ-009 frame_err  output  1  SHALL pulse high for one cycle when a stop bit samples 0.

Function
REQ-010 BAUD_DIV SHALL be CLK_FREQ/BAUD_RATE using integer division (868 at defaults); HALF SHALL be BAUD_DIV/2 (434); the baud counter SHALL be 16 bits.
REQ-011 rx SHALL pass through a 2-flop synchronizer (rx_s) before any use; it adds 2 cycles of latency.
REQ-012 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-013 The FSM SHALL have states IDLE, START, DATA and STOP, and rx_busy SHALL equal (state != IDLE).
REQ-014 IDLE: when rx_s==0 and the armed flag is set -> START, counter=0; the armed flag SHALL set after rx_s has been seen high for at least 1 cycle in IDLE.
REQ-015 START: counter SHALL count to HALF-1; at that cycle, sample 0 -> DATA (counter=0, bit_idx=0); sample 1 -> IDLE (false start, no output pulses).
REQ-016 DATA: each bit SHALL be sampled when the counter reaches BAUD_DIV-1; the sample SHALL shift into the MSB of an 8-bit shift register (right shift); after bit_idx 7 -> STOP.
REQ-017 STOP: sample at counter BAUD_DIV-1; sample 1 -> rx_data<=shift register and rx_valid=1 on the next cycle; sample 0 -> frame_err=1, rx_data unchanged, armed cleared; both cases -> IDLE.
REQ-018 rx_valid and frame_err SHALL never be high in the same cycle and SHALL each be high for exactly one cycle per frame.
REQ-019 The falling edge on rx to rx_valid latency SHALL be 2 + 1 + HALF + 9*BAUD_DIV cycles, +-1 cycle.
REQ-020 A new start bit SHALL be accepted in the cycle after returning to IDLE from a valid stop bit, which allows back-to-back frames.
REQ-021 A line held low (break) SHALL yield at most one frame_err and no further frames until rx_s returns high.

Reset
REQ-022 While rst_n==0: state=IDLE, counters=0, shift register=0, synchronizer flops=1, armed=0, rx_data=8'h00, rx_valid=0, rx_busy=0, frame_err=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no pulses; after release, reception SHALL resume only after rx_s is seen high.

Configuration
REQ-024 Macro UART_RX_MAJORITY_EN defined: each start, data and stop sample SHALL be the 2-of-3 majority of rx_s at sample point -1, 0 and +1 cycle; the decision SHALL take effect at the +1 cycle, and all later timing SHALL shift by 1 cycle.
REQ-025 UART_RX_MAJORITY_EN undefined: each sample SHALL be the single rx_s value at the sample point, and no majority logic SHALL be present.

Structure
REQ-026 Package uart_pkg SHALL hold the FSM state encodings, the 10-bit frame length constant, and the BAUD_DIV/HALF calculation, all shared with the transmitter.
REQ-027 Sub-module uart_rx_sync SHALL implement the 2-flop synchronizer with reset value 1.

Verification
REQ-028 Send 0x55 at defaults -> exactly one rx_valid pulse, rx_data=0x55, frame_err never high, rx_busy low afterwards.
REQ-029 Send 0xA5 then 0x3C back-to-back with zero idle -> two rx_valid pulses in order, data 0xA5 then 0x3C.
REQ-030 Drive a 100-cycle low glitch on an idle line -> START then IDLE, no rx_valid, no frame_err, rx_busy high for fewer than 440 cycles.
REQ-031 Send 0xFF with the stop bit forced 0, then hold the line low for 20 bit times -> one frame_err, rx_data holds its previous value, no further pulses until the line goes high.
REQ-032 Assert rst_n at bit 4 of 0x81, release it, then send 0x7E -> no output for 0x81, rx_valid with 0x7E, all outputs at reset values during reset.
REQ-033 With UART_RX_MAJORITY_EN defined, inject a 1-cycle inverted pulse on the bit-3 sample point of 0x00 -> rx_data=0x00; with the macro undefined -> rx_data=0x08.
